// File: rtl/commit_trace_queue.sv
// Commit-to-tracer record queue.
// Captures each retired instruction (npc, inst) together with the number of
// cycles since the previous retirement. Records sit in a small
// first-word-fall-through FIFO that the tracer drains. When the FIFO is full,
// the queue backpressures the commit stage.
// Optional statistics outputs are enabled by defining COMMIT_TRACE_QUEUE_STATS_EN.
module commit_trace_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_npc,
  input  logic [31:0]                in_inst,
  input  logic                       out_ready,
  output logic                       out_en,
  output logic [31:0]                out_npc,
  output logic [31:0]                out_inst,
  output logic [CNT_W-1:0]           out_exec_cycle,
`ifdef COMMIT_TRACE_QUEUE_STATS_EN
  output logic [63:0]                retired_total,
  output logic [$clog2(DEPTH):0]     max_occupancy,
  output logic [63:0]                stall_cycles,
`endif
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [PW-1:0] PtrOne = PW'(1);
  localparam logic [CW-1:0] CntOne = CW'(1);
  localparam logic [CW-1:0] CntFull = CW'(DEPTH);

  logic [31:0]      npc_mem   [DEPTH];
  logic [31:0]      inst_mem  [DEPTH];
  logic [CNT_W-1:0] stamp_mem [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] cyc_inc;
  logic             full, empty, push, pop;

  // Handshake decode; full and empty come from the occupancy register only.
  always_comb begin
    full     = (count_q == CntFull);
    empty    = (count_q == '0);
    in_ready = !full;
    out_en   = !empty && out_ready;
    push     = in_valid && in_ready;
    pop      = out_en;
    count    = count_q;
    out_npc        = npc_mem[rd_ptr_q];
    out_inst       = inst_mem[rd_ptr_q];
    out_exec_cycle = stamp_mem[rd_ptr_q];
  end

  // Pointer, occupancy and cycle-counter next state.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
    // Saturating increment; a push stamps this value and restarts the count.
    cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1);
    cyc_d   = push ? '0 : cyc_inc;
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cyc_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cyc_q    <= cyc_d;
    end
  end

  // Record storage; cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        npc_mem[i]   <= '0;
        inst_mem[i]  <= '0;
        stamp_mem[i] <= '0;
      end
    end else if (push) begin
      npc_mem[wr_ptr_q]   <= in_npc;
      inst_mem[wr_ptr_q]  <= in_inst;
      stamp_mem[wr_ptr_q] <= cyc_inc;
    end
  end

`ifdef COMMIT_TRACE_QUEUE_STATS_EN
  logic [63:0]   retired_q, retired_d;
  logic [63:0]   stall_q, stall_d;
  logic [CW-1:0] max_occ_q, max_occ_d;

  // Saturating event counters and occupancy high-water mark.
  always_comb begin
    retired_d = retired_q;
    stall_d   = stall_q;
    if (push && (retired_q != '1)) retired_d = retired_q + 64'd1;
    if (in_valid && !in_ready && (stall_q != '1)) stall_d = stall_q + 64'd1;
    max_occ_d = (count_d > max_occ_q) ? count_d : max_occ_q;
    retired_total = retired_q;
    stall_cycles  = stall_q;
    max_occupancy = max_occ_q;
  end

  // Statistics registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
      stall_q   <= '0;
      max_occ_q <= '0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
      max_occ_q <= max_occ_d;
    end
  end
`endif

endmodule

// File: tb/tb_commit_trace_queue.sv
// Directed self-checking bench for commit_trace_queue.
// A second instance with an 8-bit cycle counter covers counter saturation.
module tb_commit_trace_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_npc = '0;
  logic [31:0] in_inst = '0;
  logic        out_ready = 1'b0;
  logic        out_en;
  logic [31:0] out_npc;
  logic [31:0] out_inst;
  logic [63:0] out_exec_cycle;
  logic [2:0]  count;

  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic        s_out_en;
  logic [31:0] s_out_npc;
  logic [31:0] s_out_inst;
  logic [7:0]  s_out_exec_cycle;
  logic [2:0]  s_count;

`ifdef COMMIT_TRACE_QUEUE_STATS_EN
  logic [63:0] retired_total, stall_cycles, s_retired_total, s_stall_cycles;
  logic [2:0]  max_occupancy, s_max_occupancy;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  commit_trace_queue #(.DEPTH(4), .CNT_W(64)) u_dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_npc         (in_npc),
    .in_inst        (in_inst),
    .out_ready      (out_ready),
    .out_en         (out_en),
    .out_npc        (out_npc),
    .out_inst       (out_inst),
    .out_exec_cycle (out_exec_cycle),
`ifdef COMMIT_TRACE_QUEUE_STATS_EN
    .retired_total  (retired_total),
    .max_occupancy  (max_occupancy),
    .stall_cycles   (stall_cycles),
`endif
    .count          (count)
  );

  commit_trace_queue #(.DEPTH(4), .CNT_W(8)) u_dut8 (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (s_in_valid),
    .in_ready       (s_in_ready),
    .in_npc         (32'h0000_1234),
    .in_inst        (32'h0000_0013),
    .out_ready      (1'b1),
    .out_en         (s_out_en),
    .out_npc        (s_out_npc),
    .out_inst       (s_out_inst),
    .out_exec_cycle (s_out_exec_cycle),
`ifdef COMMIT_TRACE_QUEUE_STATS_EN
    .retired_total  (s_retired_total),
    .max_occupancy  (s_max_occupancy),
    .stall_cycles   (s_stall_cycles),
`endif
    .count          (s_count)
  );

  // Advance past the next rising edge; outputs are then stable for checking.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Hold reset over one edge and release 1 time unit after it, so the next
  // rising edge is edge 1 after release.
  task automatic do_reset();
    in_valid   = 1'b0;
    s_in_valid = 1'b0;
    out_ready  = 1'b0;
    reset      = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_npc    = 32'hDEAD_BEEF;
    tick();
    tick();
    n_vec++;
    if (count !== 3'd0) begin
      n_err++; $display("FAIL reset_count: got %0d want 0", count);
    end
    n_vec++;
    if (out_en !== 1'b0) begin
      n_err++; $display("FAIL reset_out_en: got %b want 0", out_en);
    end
    n_vec++;
    if (out_npc !== 32'h0 || out_exec_cycle !== 64'h0) begin
      n_err++; $display("FAIL reset_head: got npc %h cyc %0d want 0 0", out_npc, out_exec_cycle);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    in_valid = 1'b0;
    reset    = 1'b1;
  endtask

  // Pushes at edges 3, 4, 7 with out_ready=1.
  task automatic test_basic();
    logic [31:0] npc_exp;
    logic [63:0] cyc_exp;
    logic        en_exp;
    do_reset();
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = (k == 3) || (k == 4) || (k == 7);
      in_npc   = (k == 3) ? 32'h8000_0004 : (k == 4) ? 32'h8000_0008 : 32'h8000_000C;
      in_inst  = 32'h0000_0013 + k;
      tick();
      en_exp  = (k == 3) || (k == 4) || (k == 7);
      npc_exp = in_npc;
      cyc_exp = (k == 4) ? 64'd1 : 64'd3;
      n_vec++;
      if (out_en !== en_exp) begin
        n_err++; $display("FAIL basic_en edge %0d: got %b want %b", k, out_en, en_exp);
      end
      if (en_exp) begin
        n_vec++;
        if (out_exec_cycle !== cyc_exp || out_npc !== npc_exp) begin
          n_err++;
          $display("FAIL basic_rec edge %0d: got cyc %0d npc %h want cyc %0d npc %h",
                   k, out_exec_cycle, out_npc, cyc_exp, npc_exp);
        end
      end
      n_vec++;
      if (count > 3'd1) begin
        n_err++; $display("FAIL basic_count edge %0d: got %0d want <=1", k, count);
      end
    end
    in_valid = 1'b0;
  endtask

  // Six pushes into a 4-deep queue with the tracer stalled, then drain.
  task automatic test_fill_drain();
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      in_valid = 1'b1;
      in_npc   = 32'h4000_0000 + 32'(k * 4);
      in_inst  = 32'hA000_0000 + 32'(k);
      #1;
      n_vec++;
      if (in_ready !== (k <= 4)) begin
        n_err++; $display("FAIL fill_in_ready push %0d: got %b want %b", k, in_ready, k <= 4);
      end
      tick();
    end
    in_valid = 1'b0;
    n_vec++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL fill_full: got count %0d rdy %b want 4 0", count, in_ready);
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      n_vec++;
      if (out_en !== 1'b1 || out_npc !== 32'h4000_0000 + 32'(k * 4) ||
          out_inst !== 32'hA000_0000 + 32'(k) || out_exec_cycle !== 64'd1) begin
        n_err++;
        $display("FAIL drain_rec %0d: got en %b npc %h inst %h cyc %0d want 1 %h %h 1",
                 k, out_en, out_npc, out_inst, out_exec_cycle,
                 32'h4000_0000 + 32'(k * 4), 32'hA000_0000 + 32'(k));
      end
      tick();
      if (k == 1) begin
        n_vec++;
        if (in_ready !== 1'b1) begin
          n_err++; $display("FAIL drain_in_ready: got %b want 1", in_ready);
        end
      end
    end
    n_vec++;
    if (out_en !== 1'b0 || count !== 3'd0) begin
      n_err++; $display("FAIL drain_empty: got en %b count %0d want 0 0", out_en, count);
    end
    out_ready = 1'b0;
  endtask

  // Full queue, 5 stalled commit cycles, one pop, then the stalled push lands.
  task automatic test_stall();
    do_reset();
    in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_npc = 32'h5000_0000 + 32'(k);
      tick();
    end
    in_npc = 32'h5000_00FF;
    for (int k = 1; k <= 5; k++) tick();
`ifdef COMMIT_TRACE_QUEUE_STATS_EN
    n_vec++;
    if (stall_cycles !== 64'd5) begin
      n_err++; $display("FAIL stall_cycles: got %0d want 5", stall_cycles);
    end
`endif
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (count !== 3'd4) begin
      n_err++; $display("FAIL stall_count: got %0d want 4", count);
    end
`ifdef COMMIT_TRACE_QUEUE_STATS_EN
    n_vec++;
    if (stall_cycles !== 64'd5 || retired_total !== 64'd5 || max_occupancy !== 3'd4) begin
      n_err++;
      $display("FAIL stall_stats: got stall %0d ret %0d max %0d want 5 5 4",
               stall_cycles, retired_total, max_occupancy);
    end
`endif
    out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) tick();
    n_vec++;
    if (out_en !== 1'b1 || out_npc !== 32'h5000_00FF || out_exec_cycle !== 64'd7) begin
      n_err++;
      $display("FAIL stall_stamp: got en %b npc %h cyc %0d want 1 500000ff 7",
               out_en, out_npc, out_exec_cycle);
    end
    tick();
    out_ready = 1'b0;
  endtask

  // Steady state at count=2 with a push and pop every cycle for 10 cycles.
  task automatic test_wrap();
    do_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_npc  = 32'h0000_1000 + 32'(k * 4);
      in_inst = 32'hB000_0000 + 32'(k);
      tick();
    end
    out_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      in_npc  = 32'h0000_1000 + 32'((j + 2) * 4);
      in_inst = 32'hB000_0000 + 32'(j + 2);
      #1;
      n_vec++;
      if (out_en !== 1'b1 || out_npc !== 32'h0000_1000 + 32'(j * 4) ||
          out_inst !== 32'hB000_0000 + 32'(j)) begin
        n_err++;
        $display("FAIL wrap_rec %0d: got en %b npc %h inst %h want 1 %h %h", j, out_en,
                 out_npc, out_inst, 32'h0000_1000 + 32'(j * 4), 32'hB000_0000 + 32'(j));
      end
      tick();
      n_vec++;
      if (count !== 3'd2) begin
        n_err++; $display("FAIL wrap_count %0d: got %0d want 2", j, count);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  // Asynchronous reset with three records queued.
  task automatic test_reset_mid();
    do_reset();
    in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      in_npc = 32'h6000_0000 + 32'(k);
      tick();
    end
    in_valid = 1'b0;
    n_vec++;
    if (count !== 3'd3) begin
      n_err++; $display("FAIL mid_pre_count: got %0d want 3", count);
    end
    out_ready = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    n_vec++;
    if (out_en !== 1'b0 || count !== 3'd0) begin
      n_err++; $display("FAIL mid_async: got en %b count %0d want 0 0", out_en, count);
    end
    tick();
    reset = 1'b1;
    tick();
    n_vec++;
    if (out_en !== 1'b0) begin
      n_err++; $display("FAIL mid_stale: got en %b want 0", out_en);
    end
    in_valid = 1'b1;
    in_npc   = 32'h7000_0010;
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (out_en !== 1'b1 || out_exec_cycle !== 64'd2 || out_npc !== 32'h7000_0010 ||
        count !== 3'd1) begin
      n_err++;
      $display("FAIL mid_first: got en %b cyc %0d npc %h cnt %0d want 1 2 70000010 1",
               out_en, out_exec_cycle, out_npc, count);
    end
    tick();
    n_vec++;
    if (out_en !== 1'b0 || count !== 3'd0) begin
      n_err++; $display("FAIL mid_after: got en %b count %0d want 0 0", out_en, count);
    end
    out_ready = 1'b0;
  endtask

  // Idle 300 cycles, then push into both instances on edge 301.
  task automatic test_saturation();
    do_reset();
    out_ready = 1'b1;
    for (int k = 1; k <= 300; k++) tick();
    in_valid   = 1'b1;
    s_in_valid = 1'b1;
    in_npc     = 32'h0000_1234;
    tick();
    in_valid   = 1'b0;
    s_in_valid = 1'b0;
    n_vec++;
    if (s_out_en !== 1'b1 || s_out_exec_cycle !== 8'd255) begin
      n_err++; $display("FAIL sat_8bit: got en %b cyc %0d want 1 255", s_out_en, s_out_exec_cycle);
    end
    n_vec++;
    if (out_en !== 1'b1 || out_exec_cycle !== 64'd301) begin
      n_err++; $display("FAIL sat_64bit: got en %b cyc %0d want 1 301", out_en, out_exec_cycle);
    end
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_drain();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
